// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared encodings for the DDR user-port arbiter.
package mem_if_pkg;

    localparam logic [2:0] APP_CMD_RD = 3'b001;
    localparam logic [2:0] APP_CMD_WR = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WCMD  = 3'd2,
        ST_RCMD  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_ACK   = 3'd5
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    // Command code presented on app_cmd for a given (next) state.
    function automatic logic [2:0] cmd_for_state(input arb_state_e st);
        if (st == ST_RCMD) begin
            return APP_CMD_RD;
        end else begin
            return APP_CMD_WR;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: MIG-style app_* user-interface bundle.
interface mem_port_arbiter_if #(
    parameter int ADR_W  = 28,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16
);
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADR_W-1:0]  app_addr;
    logic              app_rdy;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [DATA_W-1:0] app_wdf_data;
    logic [MASK_W-1:0] app_wdf_mask;
    logic              app_wdf_rdy;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] app_rd_data;

    // Arbiter side: issues commands and write data.
    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
               app_wdf_data, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data
    );

    // Memory-controller side.
    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
               app_wdf_data, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker; a tie goes to the requester
// that did not win last time. last_grant only moves when a grant is taken.
module rr_arb2
    import mem_if_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_en,
    input  logic   i_req_ic,
    input  logic   i_req_dc,
    output logic   o_gnt_valid,
    output owner_e o_gnt_owner
);

    owner_e r_last_grant;

    // Pick a winner among the pending requests.
    always_comb begin
        o_gnt_valid = i_en & (i_req_ic | i_req_dc);
        o_gnt_owner = OWN_IC;
        if (i_req_ic && i_req_dc) begin
            o_gnt_owner = (r_last_grant == OWN_IC) ? OWN_DC : OWN_IC;
        end else if (i_req_dc) begin
            o_gnt_owner = OWN_DC;
        end else begin
            o_gnt_owner = OWN_IC;
        end
    end

    // Remember the last winner; reset to IC so the first tie goes to D$.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= OWN_IC;
        end else if (o_gnt_valid) begin
            r_last_grant <= o_gnt_owner;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one DDR app_* port between I$ refills and D$
// refills/writebacks, one line-sized transaction at a time.
module mem_port_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADR_W  = 28,
    parameter int DATA_W = 128,
    parameter int MASK_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_calib_complete,
    input  logic               ic_req,
    input  logic [ADR_W-1:0]   ic_adr,
    output logic               ic_ack,
    output logic [DATA_W-1:0]  ic_rdata,
    input  logic               dc_req,
    input  logic               dc_we,
    input  logic [ADR_W-1:0]   dc_adr,
    input  logic [DATA_W-1:0]  dc_wdata,
    output logic               dc_ack,
    output logic [DATA_W-1:0]  dc_rdata,
    mem_port_arbiter_if.master app,
    output logic               arb_busy
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    owner_e            r_owner;
    logic [ADR_W-1:0]  r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_ic_rdata;
    logic [DATA_W-1:0] r_dc_rdata;
    logic              r_ic_ack;
    logic              r_dc_ack;
    logic              r_app_en;
    logic [2:0]        r_app_cmd;
    logic              r_app_wdf_wren;
    logic              r_arb_busy;
    logic              w_arb_en;
    logic              w_gnt_valid;
    owner_e            w_gnt_owner;

    // Grants are only considered while idle with calibration done.
    assign w_arb_en = (r_state == ST_IDLE) && init_calib_complete;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_arb_en),
        .i_req_ic    (ic_req),
        .i_req_dc    (dc_req),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_owner (w_gnt_owner)
    );

    // Transaction sequencing: write data, command, read wait, acknowledge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    if ((w_gnt_owner == OWN_DC) && dc_we) begin
                        w_state_nxt = ST_WDATA;
                    end else begin
                        w_state_nxt = ST_RCMD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WDATA: w_state_nxt = app.app_wdf_rdy       ? ST_WCMD  : ST_WDATA;
            ST_WCMD:  w_state_nxt = app.app_rdy           ? ST_ACK   : ST_WCMD;
            ST_RCMD:  w_state_nxt = app.app_rdy           ? ST_RWAIT : ST_RCMD;
            ST_RWAIT: w_state_nxt = app.app_rd_data_valid ? ST_ACK   : ST_RWAIT;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture owner, address and write line at grant; held for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IC;
            r_adr   <= {ADR_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
        end else if (w_gnt_valid) begin
            r_owner <= w_gnt_owner;
            if (w_gnt_owner == OWN_DC) begin
                r_adr   <= dc_adr;
                r_wdata <= dc_wdata;
            end else begin
                r_adr   <= ic_adr;
                r_wdata <= {DATA_W{1'b0}};
            end
        end else begin
            r_owner <= r_owner;
            r_adr   <= r_adr;
            r_wdata <= r_wdata;
        end
    end

    // Read data lands in the owner's line register; stray valids are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ic_rdata <= {DATA_W{1'b0}};
            r_dc_rdata <= {DATA_W{1'b0}};
        end else if ((r_state == ST_RWAIT) && app.app_rd_data_valid) begin
            if (r_owner == OWN_DC) begin
                r_dc_rdata <= app.app_rd_data;
            end else begin
                r_ic_rdata <= app.app_rd_data;
            end
        end else begin
            r_ic_rdata <= r_ic_rdata;
            r_dc_rdata <= r_dc_rdata;
        end
    end

    // Handshake outputs decoded from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_app_en       <= 1'b0;
            r_app_cmd      <= 3'b000;
            r_app_wdf_wren <= 1'b0;
            r_ic_ack       <= 1'b0;
            r_dc_ack       <= 1'b0;
            r_arb_busy     <= 1'b0;
        end else begin
            r_app_en       <= (w_state_nxt == ST_RCMD) || (w_state_nxt == ST_WCMD);
            r_app_cmd      <= cmd_for_state(w_state_nxt);
            r_app_wdf_wren <= (w_state_nxt == ST_WDATA);
            r_ic_ack       <= (w_state_nxt == ST_ACK) && (r_owner == OWN_IC);
            r_dc_ack       <= (w_state_nxt == ST_ACK) && (r_owner == OWN_DC);
            r_arb_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign app.app_en       = r_app_en;
    assign app.app_cmd      = r_app_cmd;
    assign app.app_addr     = r_adr;
    assign app.app_wdf_wren = r_app_wdf_wren;
    assign app.app_wdf_end  = r_app_wdf_wren;
    assign app.app_wdf_data = r_wdata;
    assign app.app_wdf_mask = {MASK_W{1'b0}};
    assign ic_ack           = r_ic_ack;
    assign dc_ack           = r_dc_ack;
    assign ic_rdata         = r_ic_rdata;
    assign dc_rdata         = r_dc_rdata;
    assign arb_busy         = r_arb_busy;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single DDR user-interface port (MIG app_* style) between the I$ refill path and the D$ refill/writeback path.
- Sits between the two cache controllers and the memory-controller wrapper.
- Gates all traffic on init_calib_complete, the same signal that gates cpu_run_state in the status block.
- Sequences one line-sized transaction at a time: write data, command, read-data wait, then a one-cycle acknowledge to the winning requester.

Parameters:
ADR_W, 28, line-aligned DDR address width (app_addr width)
DATA_W, 128, cache line / app data width in bits
MASK_W, 16, write byte-mask width (DATA_W/8)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
init_calib_complete  in  1  DDR calibration done; no grant while 0
ic_req  in  1  I$ read request, level, held until ic_ack
ic_adr  in  ADR_W  I$ line address
ic_ack  out  1  one-cycle pulse, ic_rdata valid this cycle
ic_rdata  out  DATA_W  read line for I$
dc_req  in  1  D$ request, level, held until dc_ack
dc_we  in  1  1 = writeback, 0 = refill read
dc_adr  in  ADR_W  D$ line address
dc_wdata  in  DATA_W  writeback line
dc_ack  out  1  one-cycle completion pulse
dc_rdata  out  DATA_W  read line for D$
app_en  out  1  command valid
app_cmd  out  3  3'b001 read, 3'b000 write
app_addr  out  ADR_W  command address
app_rdy  in  1  command accepted when app_en & app_rdy
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  tied equal to app_wdf_wren (single-beat line)
app_wdf_data  out  DATA_W  write data
app_wdf_mask  out  MASK_W  always all-zero (full line write)
app_wdf_rdy  in  1  write data accepted when wren & wdf_rdy
app_rd_data_valid  in  1  read data valid
app_rd_data  in  DATA_W  read data
arb_busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = IC (first tie goes to D$), latched address/data/we 0.
- States: IDLE, WDATA, WCMD, RCMD, RWAIT, ACK.
- IDLE:
  - Grants only if init_calib_complete=1 and at least one req is high.
  - Only one pending: that requester wins.
  - Both pending: grant the one not equal to last_grant (round-robin); update last_grant on grant.
  - On grant, latch owner, adr, we (ic: we=0), and wdata.
  - Next state: WDATA if we=1, else RCMD. Grant-to-app_en/wren latency is 1 cycle.
- WDATA: app_wdf_wren = app_wdf_end = 1 with latched data; on app_wdf_rdy go to WCMD.
- WCMD: app_en=1, app_cmd=000, app_addr=latched adr; on app_rdy go to ACK.
- RCMD: app_en=1, app_cmd=001; on app_rdy go to RWAIT.
- RWAIT:
  - On app_rd_data_valid, latch app_rd_data into the owner's rdata register; go to ACK.
  - Any app_rd_data_valid outside RWAIT is ignored.
- ACK: owner's ack=1 for exactly one cycle; next state IDLE. Earliest re-grant is the cycle after ACK, so a requester keeping req high gets no back-to-back ack.
- rdata registers hold their value until the next read completion for the same requester.
- app_en/app_wdf_wren stay asserted until accepted; address and data are stable while waiting.
- Request dropped mid-transaction: the transaction completes and ack still pulses.
- init_calib_complete falling mid-transaction: the transaction completes; no new grant until it returns to 1.
- rst_n asserted mid-transaction: immediate return to reset values; no ack is produced.
- Ready or valid inputs asserted without the matching en/wren are ignored.

Decomposition:
- Shared package (mem_if_pkg): APP_CMD_RD=3'b001, APP_CMD_WR=3'b000, state encoding constants, owner encoding OWN_IC=0 / OWN_DC=1.
- Sub-module: rr_arb2, a two-requester round-robin picker with last_grant register and grant-enable input. The rest stays flat.

Test Plan:
- Calibration gating: init_calib_complete=0, ic_req=1 ic_adr=0x0000100 for 20 cycles -> no app_en. Raise calib -> app_en=1 app_cmd=001 app_addr=0x0000100 one cycle later; app_rd_data=0xDEADBEEF_..._0001 valid -> ic_ack pulse 1 cycle, ic_rdata equals it.
- D$ writeback with backpressure: dc_req=1 dc_we=1 dc_adr=0x0000200 dc_wdata=0xA5A5...; app_wdf_rdy=0 for 3 cycles -> wren held with stable data. Then app_rdy=0 for 2 cycles -> app_en held, app_cmd=000. dc_ack exactly once after acceptance.
- Tie round-robin: ic_req and dc_req both high continuously, each read completing -> grant order DC, IC, DC, IC. Exactly one ack per transaction; never an ic_ack and dc_ack in the same cycle.
- Request withdrawal: dc_req drops in RWAIT -> read still completes, dc_ack pulses once, then IDLE with arb_busy=0.
- Reset mid-op: rst_n low during RWAIT -> all outputs 0 immediately. Stray app_rd_data_valid after reset release -> no ack, state IDLE.
- Stray input: app_rd_data_valid=1 while in IDLE -> no ack, rdata unchanged.
